// File: rtl/countdown_timer.sv
// countdown_timer: programmable down counter with IDLE/RUN/DONE handshake; define COUNTDOWN_TIMER_AUTO_RELOAD_EN for periodic auto-reload
module countdown_timer #(
  parameter int MAX = 1023,
  parameter int STEP = 1,
  localparam int BITS = $clog2(MAX + 1)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_clear,
  input  logic            i_load,
  input  logic [BITS-1:0] i_load_value,
  input  logic            i_enable,
  output logic [BITS-1:0] o_count,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_expired
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          r_state, w_state;
  logic [BITS-1:0] r_count, w_count, w_load_v;
  logic            r_expired, w_expired;
  logic [BITS:0]   w_sub;
  logic            w_term;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [BITS-1:0] r_reload, w_reload;
`endif
  assign w_load_v = ({1'b0, i_load_value} > (BITS+1)'(MAX)) ? BITS'(MAX) : i_load_value;
  assign w_sub    = {1'b0, r_count} - (BITS+1)'(STEP);
  // borrow or exact zero means count <= STEP: this enabled cycle is terminal
  assign w_term   = w_sub[BITS] | (w_sub[BITS-1:0] == '0);
  // next state, count and expiry pulse; priority clear > load > enable
  always_comb begin
    w_state   = r_state;
    w_count   = r_count;
    w_expired = 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    w_reload  = r_reload;
`endif
    if (i_clear) begin
      w_state = IDLE;
      w_count = '0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      w_reload = '0;
`endif
    end else if (i_load) begin
      w_count   = w_load_v;
      w_expired = (w_load_v == '0);
      w_state   = w_expired ? DONE : RUN;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      w_reload  = w_load_v;
`endif
    end else if (r_state == RUN && i_enable && w_term) begin
      w_expired = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      w_count   = r_reload;
      w_state   = (r_reload == '0) ? DONE : RUN;
`else
      w_count   = '0;
      w_state   = DONE;
`endif
    end else if (r_state == RUN && i_enable) begin
      w_count = w_sub[BITS-1:0];
    end
  end
  // state and datapath registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= IDLE;
      r_count   <= '0;
      r_expired <= 1'b0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      r_reload  <= '0;
`endif
    end else begin
      r_state   <= w_state;
      r_count   <= w_count;
      r_expired <= w_expired;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      r_reload  <= w_reload;
`endif
    end
  end
  assign o_count   = r_count;
  assign o_busy    = (r_state == RUN);
  assign o_done    = (r_state == DONE);
  assign o_expired = r_expired;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed bench for countdown_timer against an arithmetic model (n enabled decrements since load)
module tb_countdown_timer;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  localparam int N = 3;
  logic       clk = 1'b0, reset = 1'b1, clear = 1'b0, load = 1'b0, enable = 1'b0;
  logic [9:0] lv = '0;
  logic [9:0] cnt [N];
  logic       busy [N], done [N], expd [N];
  int         vec = 0, err = 0;
  int         m_v [N], m_n [N];
  bit         m_act [N], m_exp [N];
  always #5 clk = ~clk;
  countdown_timer #(.MAX(1023), .STEP(1)) u_s1 (.i_clk(clk), .i_reset(reset), .i_clear(clear), .i_load(load),
    .i_load_value(lv), .i_enable(enable), .o_count(cnt[0]), .o_busy(busy[0]), .o_done(done[0]), .o_expired(expd[0]));
  countdown_timer #(.MAX(1023), .STEP(3)) u_s3 (.i_clk(clk), .i_reset(reset), .i_clear(clear), .i_load(load),
    .i_load_value(lv), .i_enable(enable), .o_count(cnt[1]), .o_busy(busy[1]), .o_done(done[1]), .o_expired(expd[1]));
  countdown_timer #(.MAX(1000), .STEP(1)) u_m1 (.i_clk(clk), .i_reset(reset), .i_clear(clear), .i_load(load),
    .i_load_value(lv), .i_enable(enable), .o_count(cnt[2]), .o_busy(busy[2]), .o_done(done[2]), .o_expired(expd[2]));
  function automatic int mx(int i);
    return (i == 2) ? 1000 : 1023;
  endfunction
  function automatic int st(int i);
    return (i == 1) ? 3 : 1;
  endfunction
  // enabled cycles from load value to terminal
  function automatic int per(int i);
    return (m_v[i] + st(i) - 1) / st(i);
  endfunction
  function automatic bit running(int i);
    return m_act[i] && m_v[i] != 0 && (AUTO || m_n[i] < per(i));
  endfunction
  function automatic int mcount(int i);
    if (!m_act[i] || m_v[i] == 0) return 0;
    if (AUTO) return m_v[i] - (m_n[i] % per(i)) * st(i);
    return (m_n[i] * st(i) >= m_v[i]) ? 0 : m_v[i] - m_n[i] * st(i);
  endfunction
  task automatic chk(string nm, int got, int exp);
    vec++;
    if (got != exp) begin
      err++;
      $display("FAIL %s got %0d want %0d at %0t", nm, got, exp, $time);
    end
  endtask
  // model: a load sets the value and zeroes the enabled-decrement count n
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (reset || clear) begin
        m_act[i] <= 1'b0;
        m_v[i]   <= 0;
        m_n[i]   <= 0;
        m_exp[i] <= 1'b0;
      end else if (load) begin
        m_act[i] <= 1'b1;
        m_v[i]   <= (int'(lv) > mx(i)) ? mx(i) : int'(lv);
        m_n[i]   <= 0;
        m_exp[i] <= (lv == 0);
      end else if (running(i) && enable) begin
        m_n[i]   <= m_n[i] + 1;
        m_exp[i] <= AUTO ? ((m_n[i] + 1) % per(i) == 0) : (m_n[i] + 1 == per(i));
      end else begin
        m_exp[i] <= 1'b0;
      end
    end
  end
  // compare every instance against the model on each falling edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("model_cnt%0d", i), int'(cnt[i]), mcount(i));
        chk($sformatf("model_busy%0d", i), int'(busy[i]), int'(running(i)));
        chk($sformatf("model_done%0d", i), int'(done[i]), int'(m_act[i] && !running(i)));
        chk($sformatf("model_exp%0d", i), int'(expd[i]), int'(m_exp[i]));
      end
    end
  end
  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_cnt", int'(cnt[0]), 0);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_done", int'(done[0]), 0);
    chk("rst_exp", int'(expd[0]), 0);
    load = 1'b1; lv = 10'd5; enable = 1'b1;
    @(negedge clk); load = 1'b0;
    chk("t1_load", int'(cnt[0]), 5);
    chk("t1_busy", int'(busy[0]), 1);
    repeat (4) @(negedge clk);
    chk("t1_one", int'(cnt[0]), 1);
    chk("t1_noexp", int'(expd[0]), 0);
    @(negedge clk);
    chk("t1_zero", int'(cnt[0]), AUTO ? 5 : 0);
    chk("t1_exp", int'(expd[0]), 1);
    chk("t1_done", int'(done[0]), AUTO ? 0 : 1);
    repeat (3) @(negedge clk);
    chk("t1_hold", int'(done[0]), AUTO ? 0 : 1);
    chk("t1_exp_once", int'(expd[0]), 0);
    load = 1'b1; lv = 10'd4; enable = 1'b0;
    @(negedge clk); load = 1'b0;
    for (int k = 0; k < 8; k++) begin
      enable = (k % 2 == 0);
      @(negedge clk);
      if (k == 3) chk("t2_mid", int'(cnt[0]), 2);
      if (k == 5) chk("t2_busy", int'(busy[0]), 1);
    end
    chk("t2_end", int'(cnt[0]), AUTO ? 4 : 0);
    enable = 1'b0; load = 1'b1; lv = 10'd1020;
    @(negedge clk);
    chk("t3_clamp", int'(cnt[2]), 1000);
    chk("t3_noclamp", int'(cnt[0]), 1020);
    lv = 10'd0;
    @(negedge clk); load = 1'b0;
    chk("t3_zero_done", int'(done[0]), 1);
    chk("t3_zero_exp", int'(expd[0]), 1);
    @(negedge clk);
    chk("t3_zero_pulse", int'(expd[0]), 0);
    load = 1'b1; lv = 10'd7; enable = 1'b1;
    @(negedge clk); load = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_one", int'(cnt[1]), 1);
    @(negedge clk);
    chk("t4_sat", int'(cnt[1]), AUTO ? 7 : 0);
    chk("t4_exp", int'(expd[1]), 1);
    load = 1'b1; lv = 10'd10;
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    chk("t5_seven", int'(cnt[0]), 7);
    load = 1'b1; lv = 10'd2;
    @(negedge clk); load = 1'b0;
    chk("t5_reload", int'(cnt[0]), 2);
    chk("t5_silent", int'(expd[0]), 0);
    repeat (2) @(negedge clk);
    chk("t5_term", int'(cnt[0]), AUTO ? 2 : 0);
    chk("t5_exp", int'(expd[0]), 1);
    clear = 1'b1; load = 1'b1; lv = 10'd9;
    @(negedge clk); clear = 1'b0; load = 1'b0;
    chk("t5_clr_cnt", int'(cnt[0]), 0);
    chk("t5_clr_busy", int'(busy[0]), 0);
    load = 1'b1; lv = 10'd10;
    @(negedge clk); load = 1'b0;
    repeat (4) @(negedge clk);
    chk("t5_six", int'(cnt[0]), 6);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("t5_rst_cnt", int'(cnt[0]), 0);
    chk("t5_rst_exp", int'(expd[0]), 0);
    load = 1'b1; lv = 10'd3;
    @(negedge clk); load = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_term", int'(cnt[0]), AUTO ? 3 : 0);
    chk("t6_exp", int'(expd[0]), 1);
    chk("t6_done", int'(done[0]), AUTO ? 0 : 1);
    repeat (3) @(negedge clk);
    chk("t6_exp2", int'(expd[0]), AUTO ? 1 : 0);
    clear = 1'b1;
    @(negedge clk); clear = 1'b0; enable = 1'b0;
    chk("t6_clr_busy", int'(busy[0]), 0);
    chk("t6_clr_done", int'(done[0]), 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule
